// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and index/saturation helpers for the branch predictor
package bp_pkg;

    localparam int BP_MODE_BIMODAL = 0;
    localparam int BP_MODE_GSHARE  = 1;

    localparam logic [1:0] CNT_STRONG_NT = 2'd0;
    localparam logic [1:0] CNT_WEAK_NT   = 2'd1;
    localparam logic [1:0] CNT_WEAK_T    = 2'd2;
    localparam logic [1:0] CNT_STRONG_T  = 2'd3;

    // Callers zero-extend into 32 bits and truncate the result to IDX_W.
    function automatic logic [31:0] bp_hash(input logic [31:0] base,
                                            input logic [31:0] ghr,
                                            input int          mode);
        return (mode == BP_MODE_GSHARE) ? (base ^ ghr) : base;
    endfunction

    function automatic logic [31:0] bp_sat_step(input logic [31:0] val,
                                                input logic        up,
                                                input int          bits);
        logic [31:0] max_v;
        max_v = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        if (up) begin
            return (val == max_v) ? val : val + 32'd1;
        end
        return (val == 32'd0) ? val : val - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_bht_if.sv
// rtl/branch_predictor_bht_if.sv - lookup, resolve-update and statistics signals of the BHT
interface branch_predictor_bht_if #(
    parameter int PC_WIDTH = 32,
    parameter int IDX_W    = 4,
    parameter int STAT_W   = 32
);
    logic                pred_valid;
    logic [PC_WIDTH-1:0] pred_pc;
    logic                pred_taken;
    logic [IDX_W-1:0]    pred_idx;
    logic                upd_valid;
    logic [IDX_W-1:0]    upd_idx;
    logic                upd_taken;
    logic                upd_mispredict;
    logic                stat_clr;
    logic [STAT_W-1:0]   stat_lookups;
    logic [STAT_W-1:0]   stat_mispredicts;

    modport master (
        output pred_valid, pred_pc, upd_valid, upd_idx, upd_taken, upd_mispredict, stat_clr,
        input  pred_taken, pred_idx, stat_lookups, stat_mispredicts
    );

    modport slave (
        input  pred_valid, pred_pc, upd_valid, upd_idx, upd_taken, upd_mispredict, stat_clr,
        output pred_taken, pred_idx, stat_lookups, stat_mispredicts
    );
endinterface

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - saturating up-counter with synchronous clear priority
module bp_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - bimodal/gshare branch history table with lookup and mispredict statistics
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int ENTRIES  = 16,
    parameter int CNT_BITS = 2,
    parameter int INIT_CNT = 1,
    parameter int GHR_BITS = 4,
    parameter int MODE     = BP_MODE_BIMODAL,
    parameter int STAT_W   = 32
) (
    input logic                   clk,
    input logic                   rst,
    branch_predictor_bht_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [CNT_BITS-1:0] table_q [ENTRIES];
    logic [CNT_BITS-1:0] cnt_upd_d;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [IDX_W-1:0]    base_idx;
    logic [IDX_W-1:0]    look_idx;
    logic                unused_pc_bits;

    assign base_idx       = bus.pred_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{bus.pred_pc[PC_WIDTH-1:IDX_W+2], bus.pred_pc[1:0]};
    assign look_idx       = IDX_W'(bp_hash(32'(base_idx), 32'(ghr_q), MODE));

    // Reads the registered table, so a same-cycle update is seen only next cycle.
    assign bus.pred_idx   = look_idx;
    assign bus.pred_taken = bus.pred_valid & table_q[look_idx][CNT_BITS-1];

    always_comb begin
        cnt_upd_d = CNT_BITS'(bp_sat_step(32'(table_q[bus.upd_idx]), bus.upd_taken, CNT_BITS));
    end

    generate
        if (GHR_BITS == 1) begin : g_ghr_one
            assign ghr_d = bus.upd_taken;
        end else begin : g_ghr_shift
            assign ghr_d = {ghr_q[GHR_BITS-2:0], bus.upd_taken};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CNT_BITS'(INIT_CNT);
            end
            ghr_q <= '0;
        end else if (bus.upd_valid) begin
            table_q[bus.upd_idx] <= cnt_upd_d;
            ghr_q                <= ghr_d;
        end
    end

    bp_sat_counter #(.W(STAT_W)) u_stat_lookups (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bus.stat_clr),
        .inc_i (bus.pred_valid),
        .cnt_o (bus.stat_lookups)
    );

    bp_sat_counter #(.W(STAT_W)) u_stat_mispredicts (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bus.stat_clr),
        .inc_i (bus.upd_valid & bus.upd_mispredict),
        .cnt_o (bus.stat_mispredicts)
    );
endmodule
